cpu_ctrl: RTL and testbench

- Multi-cycle control sequencer for the 16-bit basic CPU.
- Latches an instruction word from the din input and steps through time slots T0..T3.
- Drives register write/output enables, the A and G register loads, the bus source selects, and the alu_op code consumed by the ALU.
- Sits directly upstream of the ALU and its A/G registers. Every control signal the datapath needs per cycle comes from this block.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/cpu_ctrl_dec3to8.sv | 13 +
 rtl/cpu_ctrl.sv | 126 ++++++++++++
 tb/tb_cpu_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the basic CPU control sequencer and its datapath.
package cpu_pkg;

    localparam logic [1:0] ALU_NOP = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tslot_t;

    localparam int IR_W     = 9;
    localparam int IR_OP_HI = 8;
    localparam int IR_OP_LO = 6;
    localparam int IR_RX_HI = 5;
    localparam int IR_RX_LO = 3;
    localparam int IR_RY_HI = 2;
    localparam int IR_RY_LO = 0;

endpackage

// File: rtl/cpu_ctrl_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8 (
    input  logic       i_en,
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot = 8'h00;
        if (i_en) o_onehot[i_sel] = 1'b1;
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer: fetches an instruction in T0 and
// drives datapath enables for slots T1..T3.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int word = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            run,
    input  logic [word-1:0] din,
    output logic            ir_in,
    output logic [7:0]      r_in,
    output logic [7:0]      r_out,
    output logic            din_out,
    output logic            a_in,
    output logic            g_in,
    output logic            g_out,
    output logic [1:0]      alu_op,
    output logic            done
);

    tslot_t            r_state;
    logic [IR_W-1:0]   r_ir;

    logic [2:0] w_op;
    logic [2:0] w_rx;
    logic [2:0] w_ry;
    logic       w_arith;
    logic       w_rin_en;
    logic [2:0] w_rin_sel;
    logic       w_rout_en;
    logic [2:0] w_rout_sel;

    assign w_op    = r_ir[IR_OP_HI:IR_OP_LO];
    assign w_rx    = r_ir[IR_RX_HI:IR_RX_LO];
    assign w_ry    = r_ir[IR_RY_HI:IR_RY_LO];
    assign w_arith = (w_op == OP_ADD) || (w_op == OP_SUB);

    // Upper instruction bits carry no meaning for this decoder.
    generate
        if (word > IR_W) begin : g_hi
            logic w_din_unused;
            assign w_din_unused = ^din[word-1:IR_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            unique case (r_state)
                T0: begin
                    if (run) begin
                        r_ir    <= din[IR_W-1:0];
                        r_state <= T1;
                    end
                end
                T1:      r_state <= w_arith ? T2 : T0;
                T2:      r_state <= T3;
                default: r_state <= T0;
            endcase
        end
    end

    always_comb begin
        ir_in      = 1'b0;
        din_out    = 1'b0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        g_out      = 1'b0;
        alu_op     = ALU_NOP;
        done       = 1'b0;
        w_rin_en   = 1'b0;
        w_rin_sel  = w_rx;
        w_rout_en  = 1'b0;
        w_rout_sel = w_ry;
        unique case (r_state)
            T0: ir_in = run;
            T1: begin
                unique case (w_op)
                    OP_MV: begin
                        w_rout_en = 1'b1;
                        w_rin_en  = 1'b1;
                        done      = 1'b1;
                    end
                    OP_MVI: begin
                        din_out  = 1'b1;
                        w_rin_en = 1'b1;
                        done     = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rx;
                        a_in       = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                w_rout_en = 1'b1;
                g_in      = 1'b1;
                alu_op    = (w_op == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
            default: begin
                g_out    = 1'b1;
                w_rin_en = 1'b1;
                done     = 1'b1;
            end
        endcase
    end

    dec3to8 u_dec_in (
        .i_en     (w_rin_en),
        .i_sel    (w_rin_sel),
        .o_onehot (r_in)
    );

    dec3to8 u_dec_out (
        .i_en     (w_rout_en),
        .i_sel    (w_rout_sel),
        .o_onehot (r_out)
    );

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: directed instruction vectors plus a
// random stream checked against bus-exclusivity and one-hot invariants.
module tb_cpu_ctrl;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [15:0] din;
    logic        ir_in;
    logic [7:0]  r_in;
    logic [7:0]  r_out;
    logic        din_out;
    logic        a_in;
    logic        g_in;
    logic        g_out;
    logic [1:0]  alu_op;
    logic        done;

    typedef struct {
        logic [23:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_err;
    bit   inv_en;

    cpu_ctrl #(.word(16)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .din     (din),
        .ir_in   (ir_in),
        .r_in    (r_in),
        .r_out   (r_out),
        .din_out (din_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .g_out   (g_out),
        .alu_op  (alu_op),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk(
        input logic       e_ir,
        input logic [7:0] e_rin,
        input logic [7:0] e_rout,
        input logic       e_dout,
        input logic       e_a,
        input logic       e_gin,
        input logic       e_gout,
        input logic [1:0] e_alu,
        input logic       e_done
    );
        return {e_ir, e_rin, e_rout, e_dout, e_a, e_gin, e_gout, e_alu, e_done};
    endfunction

    wire [23:0] w_act = {ir_in, r_in, r_out, din_out, a_in, g_in, g_out,
                         alu_op, done};

    // Apply inputs for one cycle and queue the outputs expected during it.
    task automatic cyc(input logic rn, input logic rr, input logic [15:0] d,
                       input logic [23:0] e, input string tag);
        exp_t x;
        resetn = rn;
        run    = rr;
        din    = d;
        x.v    = e;
        x.tag  = tag;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        int   nb;
        if (q.size() > 0) begin
            x = q.pop_front();
            n_chk++;
            if (w_act !== x.v) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", x.tag, w_act, x.v);
            end
        end
        if (inv_en) begin
            nb = int'(r_out != 8'h00) + int'(din_out) + int'(g_out);
            n_chk++;
            if (nb > 1 || !$onehot0(r_in) || !$onehot0(r_out)) begin
                n_err++;
                $display("FAIL invariant: rin=%h rout=%h dout=%b gout=%b expected exclusive one-hot",
                         r_in, r_out, din_out, g_out);
            end
        end
    end

    localparam logic [23:0] Z = 24'h0;

    initial begin
        n_chk  = 0;
        n_err  = 0;
        inv_en = 1'b0;
        resetn = 1'b0;
        run    = 1'b0;
        din    = 16'h0;
        @(posedge clk);
        #1;
        inv_en = 1'b1;
        cyc(0, 0, 16'h0, Z, "reset_idle");
        cyc(1, 0, 16'h0, Z, "idle_t0");

        // MV R1,R0
        cyc(1, 1, 16'h0008, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "mv_t0");
        cyc(1, 0, 16'h0, mk(0, 8'h02, 8'h01, 0, 0, 0, 0, 0, 1), "mv_t1");
        cyc(1, 0, 16'h0, Z, "mv_after");

        // MVI R5
        cyc(1, 1, 16'h0068, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "mvi_t0");
        cyc(1, 0, 16'h1234, mk(0, 8'h20, 0, 1, 0, 0, 0, 0, 1), "mvi_t1");
        cyc(1, 0, 16'h0, Z, "mvi_after");

        // ADD R2,R3
        cyc(1, 1, 16'h0093, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "add_t0");
        cyc(1, 0, 16'h0, mk(0, 0, 8'h04, 0, 1, 0, 0, 0, 0), "add_t1");
        cyc(1, 0, 16'h0, mk(0, 0, 8'h08, 0, 0, 1, 0, 2'b01, 0), "add_t2");
        cyc(1, 0, 16'h0, mk(0, 8'h04, 0, 0, 0, 0, 1, 0, 1), "add_t3");
        cyc(1, 0, 16'h0, Z, "add_after");

        // SUB R2,R3
        cyc(1, 1, 16'h00D3, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "sub_t0");
        cyc(1, 0, 16'h0, mk(0, 0, 8'h04, 0, 1, 0, 0, 0, 0), "sub_t1");
        cyc(1, 0, 16'h0, mk(0, 0, 8'h08, 0, 0, 1, 0, 2'b10, 0), "sub_t2");
        cyc(1, 0, 16'h0, mk(0, 8'h04, 0, 0, 0, 0, 1, 0, 1), "sub_t3");
        cyc(1, 0, 16'h0, Z, "sub_after");

        // Illegal opcode, then idle hold with run low
        cyc(1, 1, 16'h01FF, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "ill_t0");
        cyc(1, 0, 16'h0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_t1");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 16'hFFFF, Z, "ill_hold");

        // Reset asserted in T2 of an ADD
        cyc(1, 1, 16'h0093, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "rst_t0");
        cyc(1, 0, 16'h0, mk(0, 0, 8'h04, 0, 1, 0, 0, 0, 0), "rst_t1");
        cyc(0, 0, 16'h0, mk(0, 0, 8'h08, 0, 0, 1, 0, 2'b01, 0), "rst_t2");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 16'h0, Z, "rst_after");

        // ADD then MV back-to-back with run held high
        cyc(1, 1, 16'h0093, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "b2b_t0");
        cyc(1, 1, 16'h0008, mk(0, 0, 8'h04, 0, 1, 0, 0, 0, 0), "b2b_t1");
        cyc(1, 1, 16'h0008, mk(0, 0, 8'h08, 0, 0, 1, 0, 2'b01, 0), "b2b_t2");
        cyc(1, 1, 16'h0008, mk(0, 8'h04, 0, 0, 0, 0, 1, 0, 1), "b2b_t3");
        cyc(1, 1, 16'h0008, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "b2b_mv_t0");
        cyc(1, 0, 16'h0, mk(0, 8'h02, 8'h01, 0, 0, 0, 0, 0, 1), "b2b_mv_t1");
        cyc(1, 0, 16'h0, Z, "b2b_after");

        // rx == ry cases
        cyc(1, 1, 16'hFE1B, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "mv33_t0");
        cyc(1, 0, 16'h0, mk(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1), "mv33_t1");
        cyc(1, 1, 16'h0092, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "add22_t0");
        cyc(1, 0, 16'h0, mk(0, 0, 8'h04, 0, 1, 0, 0, 0, 0), "add22_t1");
        cyc(1, 0, 16'h0, mk(0, 0, 8'h04, 0, 0, 1, 0, 2'b01, 0), "add22_t2");
        cyc(1, 0, 16'h0, mk(0, 8'h04, 0, 0, 0, 0, 1, 0, 1), "add22_t3");
        cyc(1, 0, 16'h0, Z, "add22_after");

        // Random stream, invariants only
        for (int i = 0; i < 10000; i++) begin
            resetn = ($urandom_range(0, 499) != 0);
            run    = $urandom_range(0, 1) == 1;
            din    = 16'($urandom);
            @(posedge clk);
            #1;
        end

        resetn = 1'b1;
        run    = 1'b0;
        repeat (2) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
